// File: rtl/hazard_scheduler.sv
// Issue interlock for the PMIPSL0 core. Each cycle it decides whether the IF/ID instruction
// launches or a bubble is inserted, using a destination scoreboard and a branch-shadow counter.
module hazard_scheduler #(
    parameter int DEPTH      = 3,
    parameter int BR_PENALTY = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       OpCode,
    input  logic [2:0]       Rs,
    input  logic [2:0]       Rt,
    input  logic [2:0]       Rd,
    output logic             Launch,
    output logic             PCStall,
    output logic             HazardStall,
    output logic             BranchStall,
    output logic [CNT_W-1:0] BubbleCount
);

    localparam int BR_W = ($clog2(BR_PENALTY + 1) < 2) ? 2 : $clog2(BR_PENALTY + 1);

    localparam logic [2:0] OP_RTYPE = 3'd0;
    localparam logic [2:0] OP_BEQ   = 3'd2;
    localparam logic [2:0] OP_ADDI  = 3'd3;
    localparam logic [2:0] OP_LW    = 3'd5;
    localparam logic [2:0] OP_SW    = 3'd6;
    localparam logic [2:0] REG_ZERO = 3'd0;

    localparam logic [BR_W-1:0]  BR_LOAD = BR_W'(BR_PENALTY);
    localparam logic [BR_W-1:0]  BR_ZERO = {BR_W{1'b0}};
    localparam logic [BR_W-1:0]  BR_ONE  = {{(BR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DEPTH-1:0] sb_valid_r;
    logic [2:0]       sb_dest_r [DEPTH];
    logic [BR_W-1:0]  br_cnt_r;
    logic             reset_hold_r;
    logic [CNT_W-1:0] bubble_count_r;

    logic             use_rs_s;
    logic             use_rt_s;
    logic             writes_s;
    logic             is_branch_s;
    logic [2:0]       dest_s;
    logic             hazard_raw_s;
    logic             br_busy_s;
    logic             launch_s;

    // Opcode decode: which fields are read, which register is written, branch flag
    always_comb begin
        use_rs_s    = 1'b0;
        use_rt_s    = 1'b0;
        writes_s    = 1'b0;
        is_branch_s = 1'b0;
        dest_s      = REG_ZERO;
        case (OpCode)
            OP_RTYPE: begin
                use_rs_s = 1'b1;
                use_rt_s = 1'b1;
                writes_s = (Rd != REG_ZERO);
                dest_s   = Rd;
            end
            OP_BEQ: begin
                use_rs_s    = 1'b1;
                use_rt_s    = 1'b1;
                is_branch_s = 1'b1;
            end
            OP_ADDI, OP_LW: begin
                use_rs_s = 1'b1;
                writes_s = (Rt != REG_ZERO);
                dest_s   = Rt;
            end
            OP_SW: begin
                use_rs_s = 1'b1;
                use_rt_s = 1'b1;
            end
            default: begin
                use_rs_s    = 1'b0;
                use_rt_s    = 1'b0;
                writes_s    = 1'b0;
                is_branch_s = 1'b0;
                dest_s      = REG_ZERO;
            end
        endcase
    end

    // RAW detection: a non-zero source matches any valid in-flight destination
    always_comb begin
        hazard_raw_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hazard_raw_s = hazard_raw_s |
                (sb_valid_r[i] &
                 ((use_rs_s & (Rs != REG_ZERO) & (sb_dest_r[i] == Rs)) |
                  (use_rt_s & (Rt != REG_ZERO) & (sb_dest_r[i] == Rt))));
        end
    end

    assign br_busy_s   = (br_cnt_r != BR_ZERO);
    assign launch_s    = ~reset_hold_r & ~br_busy_s & ~hazard_raw_s;
    assign Launch      = launch_s;
    assign PCStall     = ~launch_s;
    // Branch shadow takes priority, so a hazard is only blamed once the shadow is clear
    assign BranchStall = ~reset_hold_r & br_busy_s;
    assign HazardStall = ~reset_hold_r & ~br_busy_s & hazard_raw_s;
    assign BubbleCount = bubble_count_r;

    // Scoreboard shift register; bubbles enter as invalid entries
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sb_valid_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                sb_dest_r[i] <= REG_ZERO;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                sb_valid_r[i] <= sb_valid_r[i-1];
                sb_dest_r[i]  <= sb_dest_r[i-1];
            end
            sb_valid_r[0] <= launch_s & writes_s;
            sb_dest_r[0]  <= dest_s;
        end
    end

    // Branch shadow counter: reload on a launched BEQ, otherwise count down to zero
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            br_cnt_r <= BR_ZERO;
        end else if (launch_s && is_branch_s) begin
            br_cnt_r <= BR_LOAD;
        end else if (br_busy_s) begin
            br_cnt_r <= br_cnt_r - BR_ONE;
        end else begin
            br_cnt_r <= br_cnt_r;
        end
    end

    // Post-reset hold: forces exactly one bubble after reset release
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            reset_hold_r <= 1'b1;
        end else begin
            reset_hold_r <= 1'b0;
        end
    end

    // Saturating bubble counter, reset-hold cycles included
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bubble_count_r <= {CNT_W{1'b0}};
        end else if (!launch_s && (bubble_count_r != CNT_MAX)) begin
            bubble_count_r <= bubble_count_r + CNT_ONE;
        end else begin
            bubble_count_r <= bubble_count_r;
        end
    end

endmodule
